// File: rtl/crddrop_filter.sv
// crddrop_filter: drops outer coordinates whose inner fiber is empty.
// The inner stream is passed through unchanged; both outputs are registered.
module crddrop_filter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clk_en,
   input  logic        flush,
   input  logic        tile_en,
   input  logic [16:0] cmrg_coord_in_0,
   input  logic        cmrg_coord_in_0_valid,
   output logic        cmrg_coord_in_0_ready,
   input  logic [16:0] cmrg_coord_in_1,
   input  logic        cmrg_coord_in_1_valid,
   output logic        cmrg_coord_in_1_ready,
   output logic [16:0] cmrg_coord_out_0,
   output logic        cmrg_coord_out_0_valid,
   input  logic        cmrg_coord_out_0_ready,
   output logic [16:0] cmrg_coord_out_1,
   output logic        cmrg_coord_out_1_valid,
   input  logic        cmrg_coord_out_1_ready
);
   localparam logic [16:0] DONE_TOK = 17'h10100;

   typedef enum logic [1:0] {
      START,
      GET_OUTER,
      CHECK_INNER,
      DONE
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [16:0] r_hold;
   logic [16:0] r_out0;
   logic [16:0] r_out1;
   logic        r_v0;
   logic        r_v1;
   logic        r_emitted;
   logic        r_done_pend;

   logic        w_pop0;
   logic        w_pop1;
   logic        w_can0;
   logic        w_can1;
   logic        w_in0_data;
   logic        w_in0_done;
   logic        w_in1_data;
   logic        w_in1_done;
   logic        w_rdy0;
   logic        w_rdy1;
   logic        w_fire0;
   logic        w_fire1;
   logic        w_ld0;
   logic        w_ld1;
   logic [16:0] w_ld0_val;
   logic        w_hold_ld;
   logic        w_emit_clr;
   logic        w_emit_set;
   logic        w_pend_set;

   // A holding reg drains only when it is visible (tile_en) and accepted.
   assign w_pop0 = r_v0 & tile_en & cmrg_coord_out_0_ready;
   assign w_pop1 = r_v1 & tile_en & cmrg_coord_out_1_ready;
   assign w_can0 = ~r_v0 | w_pop0;
   assign w_can1 = ~r_v1 | w_pop1;

   assign w_in0_data = ~cmrg_coord_in_0[16];
   assign w_in0_done = (cmrg_coord_in_0 == DONE_TOK);
   assign w_in1_data = ~cmrg_coord_in_1[16];
   assign w_in1_done = (cmrg_coord_in_1 == DONE_TOK);

   assign w_fire0 = cmrg_coord_in_0_valid & w_rdy0;
   assign w_fire1 = cmrg_coord_in_1_valid & w_rdy1;

   assign cmrg_coord_in_0_ready  = w_rdy0;
   assign cmrg_coord_in_1_ready  = w_rdy1;
   assign cmrg_coord_out_0       = r_out0;
   assign cmrg_coord_out_1       = r_out1;
   assign cmrg_coord_out_0_valid = r_v0 & tile_en;
   assign cmrg_coord_out_1_valid = r_v1 & tile_en;

   // Next-state, input readys and holding-reg load controls.
   always_comb begin
      w_state_nxt = r_state;
      w_rdy0      = 1'b0;
      w_rdy1      = 1'b0;
      w_ld0       = 1'b0;
      w_ld1       = 1'b0;
      w_ld0_val   = cmrg_coord_in_0;
      w_hold_ld   = 1'b0;
      w_emit_clr  = 1'b0;
      w_emit_set  = 1'b0;
      w_pend_set  = 1'b0;
      unique case (r_state)
         START: begin
            if (tile_en) w_state_nxt = GET_OUTER;
         end
         GET_OUTER: begin
            w_rdy0 = tile_en & w_can0;
            if (w_fire0) begin
               if (w_in0_data) begin
                  w_hold_ld   = 1'b1;
                  w_emit_clr  = 1'b1;
                  w_state_nxt = CHECK_INNER;
               end else if (w_in0_done) begin
                  // Held D is never emitted as a coord.
                  w_hold_ld   = 1'b1;
                  w_emit_set  = 1'b1;
                  w_pend_set  = 1'b1;
                  w_state_nxt = CHECK_INNER;
               end else begin
                  w_ld0 = 1'b1;
               end
            end
         end
         CHECK_INNER: begin
            w_ld0_val = r_hold;
            if (r_done_pend && w_in1_done) begin
               w_rdy1 = tile_en & w_can0 & w_can1;
               if (w_fire1) begin
                  w_ld0       = 1'b1;
                  w_ld1       = 1'b1;
                  w_state_nxt = DONE;
               end
            end else if (w_in1_data) begin
               w_rdy1 = tile_en & w_can1 & (r_emitted | w_can0);
               if (w_fire1) begin
                  w_ld1 = 1'b1;
                  if (!r_emitted) begin
                     w_ld0      = 1'b1;
                     w_emit_set = 1'b1;
                  end
               end
            end else begin
               w_rdy1 = tile_en & w_can1;
               if (w_fire1) begin
                  w_ld1 = 1'b1;
                  if (!r_done_pend) w_state_nxt = GET_OUTER;
               end
            end
         end
         DONE: begin
            w_state_nxt = DONE;
         end
         default: begin
            w_state_nxt = START;
         end
      endcase
   end

   // All state advances only on enabled edges; flush clears like reset.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         r_state     <= START;
         r_hold      <= '0;
         r_out0      <= '0;
         r_out1      <= '0;
         r_v0        <= 1'b0;
         r_v1        <= 1'b0;
         r_emitted   <= 1'b0;
         r_done_pend <= 1'b0;
      end else if (clk_en) begin
         if (flush) begin
            r_state     <= START;
            r_hold      <= '0;
            r_out0      <= '0;
            r_out1      <= '0;
            r_v0        <= 1'b0;
            r_v1        <= 1'b0;
            r_emitted   <= 1'b0;
            r_done_pend <= 1'b0;
         end else begin
            r_state <= w_state_nxt;
            if (w_ld0) begin
               r_out0 <= w_ld0_val;
               r_v0   <= 1'b1;
            end else if (w_pop0) begin
               r_v0 <= 1'b0;
            end
            if (w_ld1) begin
               r_out1 <= cmrg_coord_in_1;
               r_v1   <= 1'b1;
            end else if (w_pop1) begin
               r_v1 <= 1'b0;
            end
            if (w_hold_ld) r_hold <= cmrg_coord_in_0;
            if (w_emit_clr)
               r_emitted <= 1'b0;
            else if (w_emit_set)
               r_emitted <= 1'b1;
            if (w_pend_set) r_done_pend <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_crddrop_filter.sv
// tb_crddrop_filter: directed vectors, corner sequences and random
// back-pressure checked against a stream-level model.
module tb_crddrop_filter;
   typedef logic [16:0] tok_t;
   typedef tok_t tq_t[$];

   localparam tok_t S0 = 17'h10000;
   localparam tok_t S1 = 17'h10001;
   localparam tok_t D  = 17'h10100;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, clk_en, flush, tile_en;
   tok_t i0, i1, o0, o1;
   logic i0_v, i0_r, i1_v, i1_r;
   logic o0_v, o0_r, o1_v, o1_r;

   crddrop_filter dut (
      .clk                    (clk),
      .rst_n                  (rst),
      .clk_en                 (clk_en),
      .flush                  (flush),
      .tile_en                (tile_en),
      .cmrg_coord_in_0        (i0),
      .cmrg_coord_in_0_valid  (i0_v),
      .cmrg_coord_in_0_ready  (i0_r),
      .cmrg_coord_in_1        (i1),
      .cmrg_coord_in_1_valid  (i1_v),
      .cmrg_coord_in_1_ready  (i1_r),
      .cmrg_coord_out_0       (o0),
      .cmrg_coord_out_0_valid (o0_v),
      .cmrg_coord_out_0_ready (o0_r),
      .cmrg_coord_out_1       (o1),
      .cmrg_coord_out_1_valid (o1_v),
      .cmrg_coord_out_1_ready (o1_r)
   );

   int n_cmp = 0;
   int n_bad = 0;

   tq_t got0, got1, q_o, q_i, q_e;
   int  st0[$];
   int  st1[$];

   typedef struct {
      tok_t o[8];
      int   no;
      tok_t i[8];
      int   ni;
      tok_t e[8];
      int   ne;
   } vec_t;
   vec_t tv[3];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic cmpq(input string nm, input tq_t a, input tq_t e);
      chk({nm, "_len"}, a.size(), e.size());
      for (int k = 0; k < e.size() && k < a.size(); k++)
         chk($sformatf("%s[%0d]", nm, k), 32'(a[k]), 32'(e[k]));
   endtask

   // Outer coord survives iff its inner fiber holds any data token.
   function automatic tq_t model(input tq_t o, input tq_t i);
      tq_t r;
      int  p;
      bit  ne;
      r = {};
      p = 0;
      foreach (o[k]) begin
         if (!o[k][16]) begin
            ne = 0;
            while (p < i.size() && !i[p][16]) begin
               ne = 1;
               p++;
            end
            p++;
            if (ne) r.push_back(o[k]);
         end else begin
            r.push_back(o[k]);
         end
      end
      return r;
   endfunction

   task automatic gen();
      int   nf, nc, nd;
      tok_t c;
      q_o = {};
      q_i = {};
      nf = $urandom_range(1, 3);
      for (int f = 0; f < nf; f++) begin
         nc = $urandom_range(1, 3);
         c  = '0;
         for (int k = 0; k < nc; k++) begin
            c = c + tok_t'($urandom_range(1, 50));
            q_o.push_back(c);
            nd = $urandom_range(0, 4) > 1 ? $urandom_range(1, 3) : 0;
            for (int j = 0; j < nd; j++)
               q_i.push_back(tok_t'($urandom_range(0, 65535)));
            q_i.push_back(k == nc - 1 ? S1 : S0);
         end
         q_o.push_back(S0);
      end
      q_o.push_back(D);
      q_i.push_back(D);
   endtask

   task automatic do_reset();
      rst = 1; clk_en = 0; flush = 0; tile_en = 1;
      i0 = '0; i1 = '0; i0_v = 0; i1_v = 0; o0_r = 0; o1_r = 0;
      @(negedge clk);
      @(negedge clk);
      rst = 0;
   endtask

   // mode 0: free flow, 1: random, 2: out_0_ready low first 10 cycles
   task automatic run(input tq_t o, input tq_t i, input tq_t e0,
                      input int mode, input string tag);
      int p0, p1, cyc, post;
      bit f0, f1, d0, d1;
      p0 = 0; p1 = 0; cyc = 0; post = 0;
      f0 = 0; f1 = 0; d0 = 0; d1 = 0;
      got0 = {}; got1 = {}; st0 = {}; st1 = {};
      i0_v = 0; i1_v = 0;
      while (post < 6 && cyc < 3000) begin
         @(negedge clk);
         if (f0) begin p0++; i0_v = 0; end
         if (f1) begin p1++; i1_v = 0; end
         if (mode == 1) begin
            clk_en = ($urandom_range(0, 7) != 0);
            o0_r   = ($urandom_range(0, 2) != 0);
            o1_r   = ($urandom_range(0, 2) != 0);
         end else begin
            clk_en = 1;
            o0_r   = !(mode == 2 && cyc < 10);
            o1_r   = 1;
         end
         if (!i0_v && p0 < o.size())
            i0_v = (mode != 1) || ($urandom_range(0, 3) != 0);
         if (!i1_v && p1 < i.size())
            i1_v = (mode != 1) || ($urandom_range(0, 3) != 0);
         i0 = (p0 < o.size()) ? o[p0] : '0;
         i1 = (p1 < i.size()) ? i[p1] : '0;
         #1;
         if (mode == 2 && cyc == 8) begin
            chk("stall_in0_ready", i0_r, 0);
            chk("stall_in1_ready", i1_r, 0);
            chk("stall_out0_valid", o0_v, 1);
            chk("stall_out0", o0, 2);
         end
         f0 = i0_v & i0_r & clk_en;
         f1 = i1_v & i1_r & clk_en;
         if (o0_v & o0_r & clk_en) begin
            got0.push_back(o0);
            st0.push_back(cyc);
            if (o0 == D) d0 = 1;
         end
         if (o1_v & o1_r & clk_en) begin
            got1.push_back(o1);
            st1.push_back(cyc);
            if (o1 == D) d1 = 1;
         end
         if (d0 && d1) post++;
         cyc++;
      end
      i0_v = 0;
      i1_v = 0;
      chk({tag, "_done_seen"}, d0 && d1, 1);
      cmpq({tag, "_out0"}, got0, e0);
      cmpq({tag, "_out1"}, got1, i);
   endtask

   // Leaves the DUT in CHECK_INNER holding coord 1 with both regs full.
   task automatic prime();
      do_reset();
      @(negedge clk);
      clk_en = 1; o0_r = 0; o1_r = 0;
      i0 = 17'd1; i0_v = 1; i1 = 17'd5; i1_v = 1;
      repeat (5) @(negedge clk);
      #1;
   endtask

   task automatic load_vec(input int t);
      q_o = {}; q_i = {}; q_e = {};
      for (int k = 0; k < tv[t].no; k++) q_o.push_back(tv[t].o[k]);
      for (int k = 0; k < tv[t].ni; k++) q_i.push_back(tv[t].i[k]);
      for (int k = 0; k < tv[t].ne; k++) q_e.push_back(tv[t].e[k]);
   endtask

   initial begin
      tv[0].o = '{17'd1, 17'd2, S0, D, 0, 0, 0, 0}; tv[0].no = 4;
      tv[0].i = '{17'd5, S0, S1, D, 0, 0, 0, 0};    tv[0].ni = 4;
      tv[0].e = '{17'd1, S0, D, 0, 0, 0, 0, 0};     tv[0].ne = 3;
      tv[1].o = '{17'd3, 17'd4, S0, D, 0, 0, 0, 0}; tv[1].no = 4;
      tv[1].i = '{17'd7, 17'd8, S0, 17'd9, S1, D, 0, 0}; tv[1].ni = 6;
      tv[1].e = '{17'd3, 17'd4, S0, D, 0, 0, 0, 0}; tv[1].ne = 4;
      tv[2].o = '{17'd1, 17'd2, S0, D, 0, 0, 0, 0}; tv[2].no = 4;
      tv[2].i = '{S0, S1, D, 0, 0, 0, 0, 0};        tv[2].ni = 3;
      tv[2].e = '{S0, D, 0, 0, 0, 0, 0, 0};         tv[2].ne = 2;

      do_reset();
      #1;
      chk("rst_out0_valid", o0_v, 0);
      chk("rst_out1_valid", o1_v, 0);
      chk("rst_out0", o0, 0);
      chk("rst_out1", o1, 0);
      chk("rst_in0_ready", i0_r, 0);
      chk("rst_in1_ready", i1_r, 0);

      for (int t = 0; t < 3; t++) begin
         load_vec(t);
         do_reset();
         run(q_o, q_i, q_e, 0, $sformatf("vec%0d", t));
         if (t == 1 && st0.size() > 0 && st1.size() > 0)
            chk("vec1_same_edge", st0[0], st1[0]);
      end

      do_reset();
      q_o = '{17'd2, 17'd9, S0, D};
      q_i = '{17'd1, S0, 17'd5, 17'd6, S1, D};
      q_e = '{17'd2, 17'd9, S0, D};
      run(q_o, q_i, q_e, 2, "stall");

      prime();
      chk("prime_out0", o0, 1);
      chk("prime_out1", o1, 5);
      chk("prime_in0_ready", i0_r, 0);
      tile_en = 0;
      #1;
      chk("tile_off_out0_valid", o0_v, 0);
      chk("tile_off_in1_ready", i1_r, 0);
      tile_en = 1;
      @(negedge clk);
      clk_en = 0; o0_r = 1; o1_r = 1;
      repeat (3) @(negedge clk);
      #1;
      chk("freeze_out0_valid", o0_v, 1);
      chk("freeze_out1_valid", o1_v, 1);
      chk("freeze_out0", o0, 1);
      rst = 1;
      @(negedge clk);
      #1;
      chk("midrst_out0_valid", o0_v, 0);
      chk("midrst_out1_valid", o1_v, 0);
      chk("midrst_out0", o0, 0);
      chk("midrst_in0_ready", i0_r, 0);
      rst = 0;
      load_vec(0);
      run(q_o, q_i, q_e, 0, "after_rst");

      prime();
      flush = 1;
      @(negedge clk);
      flush = 0;
      i0_v = 0; i1_v = 0;
      #1;
      chk("flush_out0_valid", o0_v, 0);
      chk("flush_out1_valid", o1_v, 0);
      chk("flush_out1", o1, 0);
      load_vec(0);
      run(q_o, q_i, q_e, 0, "after_flush");

      for (int r = 0; r < 10; r++) begin
         gen();
         q_e = model(q_o, q_i);
         do_reset();
         run(q_o, q_i, q_e, 1, $sformatf("rand%0d", r));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
